// File: rtl/fe_pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, arbitrates WB/MEM/AGEX redirects, applies DE back-pressure
// and inserts a refill bubble window after each redirect. Define FE_PERF_CNT_EN for the perf counters.
module fe_pc_sequencer #(
    parameter int               DBITS         = 32,
    parameter logic [DBITS-1:0] STARTPC       = '0,
    parameter int               INSTSIZE      = 4,
    parameter int               REFILL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_DE,
    input  logic             br_mispred_AGEX,
    input  logic [DBITS-1:0] br_target_AGEX,
    input  logic             redir_MEM,
    input  logic [DBITS-1:0] redir_target_MEM,
    input  logic             redir_WB,
    input  logic [DBITS-1:0] redir_target_WB,
    output logic [DBITS-1:0] pc_FE,
    output logic             fetch_valid_FE,
    output logic             hold_FE_latch,
    output logic             flush_FE_latch,
    output logic             flush_DE_latch,
    output logic             flush_AGEX_latch,
`ifdef FE_PERF_CNT_EN
    output logic [DBITS-1:0] perf_stall_cycles,
    output logic [DBITS-1:0] perf_redirects,
`endif
    output logic [DBITS-1:0] inst_count_FE
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STALL  = 2'd2;
    localparam logic [1:0] REFILL = 2'd3;

    localparam logic [3:0]       REFILL_LD = 4'(REFILL_CYCLES);
    localparam logic [DBITS-1:0] PC_STEP   = DBITS'(INSTSIZE);
    localparam logic [DBITS-1:0] ALIGN     = ~DBITS'(3);

    logic [1:0]       state;
    logic [3:0]       refill_cnt;
    logic             any_redir;
    logic [DBITS-1:0] redir_target;

    assign any_redir = redir_WB | redir_MEM | br_mispred_AGEX;

    // Oldest instruction wins; targets are forced word-aligned.
    always_comb begin
        redir_target = br_target_AGEX;
        if (redir_MEM) redir_target = redir_target_MEM;
        if (redir_WB)  redir_target = redir_target_WB;
        redir_target = redir_target & ALIGN;
    end

    always_comb begin
        fetch_valid_FE = 1'b0;
        hold_FE_latch  = 1'b0;
        if (state == RUN) begin
            fetch_valid_FE = ~stall_DE;
        end
        if (state == RUN || state == STALL) begin
            hold_FE_latch = stall_DE & ~any_redir;
        end
    end

    assign flush_FE_latch   = reset & any_redir;
    assign flush_DE_latch   = reset & (redir_MEM | redir_WB);
    assign flush_AGEX_latch = reset & redir_WB;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            pc_FE         <= STARTPC;
            inst_count_FE <= DBITS'(1);
            refill_cnt    <= 4'd0;
        end else if (any_redir) begin
            pc_FE      <= redir_target;
            refill_cnt <= REFILL_LD;
            state      <= (REFILL_LD == 4'd0) ? RUN : REFILL;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (stall_DE) begin
                        state <= STALL;
                    end else begin
                        pc_FE         <= pc_FE + PC_STEP;
                        inst_count_FE <= inst_count_FE + DBITS'(1);
                    end
                end
                STALL: begin
                    if (!stall_DE) state <= RUN;
                end
                REFILL: begin
                    // The bubble window runs down even while DE is stalled.
                    refill_cnt <= refill_cnt - 4'd1;
                    if (refill_cnt <= 4'd1) state <= stall_DE ? STALL : RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (state == STALL) perf_stall_cycles <= perf_stall_cycles + DBITS'(1);
            if (any_redir)      perf_redirects    <= perf_redirects + DBITS'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fe_pc_sequencer.sv
// Directed table-driven bench for fe_pc_sequencer (default parameters, REFILL_CYCLES=1).
// Each row holds the inputs of one cycle and the outputs expected during that cycle.
module tb_fe_pc_sequencer;

    typedef struct {
        logic        stall;
        logic        agex;
        logic [31:0] agex_t;
        logic        mem;
        logic [31:0] mem_t;
        logic        wb;
        logic [31:0] wb_t;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        ffe;
        logic        fde;
        logic        fag;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_DE = 1'b0;
    logic        br_mispred_AGEX = 1'b0;
    logic [31:0] br_target_AGEX = '0;
    logic        redir_MEM = 1'b0;
    logic [31:0] redir_target_MEM = '0;
    logic        redir_WB = 1'b0;
    logic [31:0] redir_target_WB = '0;
    logic [31:0] pc_FE;
    logic        fetch_valid_FE;
    logic        hold_FE_latch;
    logic        flush_FE_latch;
    logic        flush_DE_latch;
    logic        flush_AGEX_latch;
    logic [31:0] inst_count_FE;
`ifdef FE_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    int checks = 0;
    int failures = 0;
    vec_t tbl[23];
    vec_t hv;

    always #5 clk = ~clk;

    fe_pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .stall_DE         (stall_DE),
        .br_mispred_AGEX  (br_mispred_AGEX),
        .br_target_AGEX   (br_target_AGEX),
        .redir_MEM        (redir_MEM),
        .redir_target_MEM (redir_target_MEM),
        .redir_WB         (redir_WB),
        .redir_target_WB  (redir_target_WB),
        .pc_FE            (pc_FE),
        .fetch_valid_FE   (fetch_valid_FE),
        .hold_FE_latch    (hold_FE_latch),
        .flush_FE_latch   (flush_FE_latch),
        .flush_DE_latch   (flush_DE_latch),
        .flush_AGEX_latch (flush_AGEX_latch),
`ifdef FE_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_redirects   (perf_redirects),
`endif
        .inst_count_FE    (inst_count_FE)
    );

    function automatic vec_t mk(logic s, logic a, logic [31:0] at, logic m, logic [31:0] mt,
                                logic w, logic [31:0] wt, logic [31:0] pc, logic v, logic h,
                                logic ffe, logic fde, logic fag, logic [31:0] cnt);
        vec_t r;
        r.stall = s;  r.agex = a; r.agex_t = at; r.mem = m; r.mem_t = mt;
        r.wb = w;     r.wb_t = wt; r.pc = pc; r.v = v; r.h = h;
        r.ffe = ffe;  r.fde = fde; r.fag = fag; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_DE         = v.stall;
        br_mispred_AGEX  = v.agex;
        br_target_AGEX   = v.agex_t;
        redir_MEM        = v.mem;
        redir_target_MEM = v.mem_t;
        redir_WB         = v.wb;
        redir_target_WB  = v.wb_t;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, ".pc"},    pc_FE, v.pc);
        check({tag, ".valid"}, 32'(fetch_valid_FE), 32'(v.v));
        check({tag, ".hold"},  32'(hold_FE_latch), 32'(v.h));
        check({tag, ".fl_fe"}, 32'(flush_FE_latch), 32'(v.ffe));
        check({tag, ".fl_de"}, 32'(flush_DE_latch), 32'(v.fde));
        check({tag, ".fl_ag"}, 32'(flush_AGEX_latch), 32'(v.fag));
        check({tag, ".count"}, inst_count_FE, v.cnt);
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        @(negedge clk);
        check_outs(tag, v);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset held low for three cycles; a redirect request must not leak through as a flush.
        redir_WB = 1'b1;
        redir_target_WB = 32'h0000_0500;
        repeat (3) @(posedge clk);
        #1;
        check_outs("rst", mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 1));
        redir_WB = 1'b0;
        reset = 1'b1;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h4,   1, 0, 0, 0, 0, 2);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h8,   1, 0, 0, 0, 0, 3);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'hC,   1, 0, 0, 0, 0, 4);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h10,  0, 1, 0, 0, 0, 5);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h10,  0, 1, 0, 0, 0, 5);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h10,  0, 0, 0, 0, 0, 5);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 0, 0, 5);
        tbl[9]  = mk(0, 1, 32'h100, 1, 32'h200, 1, 32'h303, 32'h14, 1, 0, 1, 1, 1, 6);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0, 0, 0, 0, 6);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0, 0, 0, 6);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 32'h304, 0, 1, 0, 0, 0, 7);
        tbl[13] = mk(1, 1, 32'h40, 0, 0, 0, 0, 32'h304, 0, 0, 1, 0, 0, 7);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 32'h40,  0, 0, 0, 0, 0, 7);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 32'h40,  0, 1, 0, 0, 0, 7);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 32'h40,  0, 0, 0, 0, 0, 7);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h40,  1, 0, 0, 0, 0, 7);
        tbl[18] = mk(0, 0, 0, 1, 32'h123, 0, 0, 32'h44, 1, 0, 1, 1, 0, 8);
        tbl[19] = mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h120, 0, 0, 1, 1, 1, 8);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 8);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 8);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0, 0, 9);

        for (int i = 0; i < 23; i++) begin
            run_vec($sformatf("row%0d", i), tbl[i]);
        end

        // Redirect into REFILL, then drop reset mid-cycle: BOOT values must appear at once.
        run_vec("pre_rst", mk(0, 1, 32'h80, 0, 0, 0, 0, 32'h4, 1, 0, 1, 0, 0, 10));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("refill.pc_before_rst", pc_FE, 32'h80);
        reset = 1'b0;
        #1;
        check_outs("mid_rst", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Redirect arriving during BOOT goes straight to REFILL.
        run_vec("boot_rd", mk(0, 1, 32'h201, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1));
        run_vec("boot_rf", mk(0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, 1));
        run_vec("boot_run", mk(0, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0, 0, 0, 0, 1));
        check("boot_run.next_pc", pc_FE, 32'h204);

        // Three STALL cycles followed by two redirect cycles.
        pulse_reset();
        run_vec("p0", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1));
        run_vec("p1", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1));
        run_vec("p2", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1));
        run_vec("p3", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1));
        run_vec("p4", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1));
        run_vec("p5", mk(0, 1, 32'h50, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1));
        run_vec("p6", mk(0, 1, 32'h60, 0, 0, 0, 0, 32'h50, 0, 0, 1, 0, 0, 1));
        run_vec("p7", mk(0, 0, 0, 0, 0, 0, 0, 32'h60, 0, 0, 0, 0, 0, 1));
        hv = mk(0, 0, 0, 0, 0, 0, 0, 32'h60, 1, 0, 0, 0, 0, 1);
        drive(hv);
        @(negedge clk);
        check_outs("p8", hv);
`ifdef FE_PERF_CNT_EN
        check("perf_stall_cycles", perf_stall_cycles, 32'd3);
        check("perf_redirects", perf_redirects, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
